// File: rtl/conv_pkg.sv
// Shared constants, types and helpers for the convolution-layer sequencer.
package conv_pkg;

   localparam int DATA_W = 32;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      MAC   = 3'd1,
      DRAIN = 3'd2,
      WRITE = 3'd3,
      DONE  = 3'd4
   } state_t;

   function automatic int out_size(input int input_size, input int filter_size, input int stride);
      return (input_size - filter_size) / stride + 1;
   endfunction

   // Address width that never collapses to zero bits for degenerate sizes.
   function automatic int addr_w(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/conv_seq_addr_gen.sv
// Loop counters (f/r/c/kr/kc) and incrementally maintained pixel, weight and
// output addresses; only adders and constant steps sit on the address paths.
module conv_seq_addr_gen
   import conv_pkg::*;
#(
   parameter int NUM_FILTERS = 16,
   parameter int INPUT_SIZE  = 28,
   parameter int FILTER_SIZE = 7,
   parameter int STRIDE      = 2,
   localparam int K        = FILTER_SIZE * FILTER_SIZE,
   localparam int OUT_SIZE = out_size(INPUT_SIZE, FILTER_SIZE, STRIDE),
   localparam int IN_AW    = addr_w(INPUT_SIZE * INPUT_SIZE),
   localparam int W_AW     = addr_w(NUM_FILTERS * K),
   localparam int OUT_AW   = addr_w(NUM_FILTERS * OUT_SIZE * OUT_SIZE)
)(
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_clear,
   input  logic              i_advance_tap,
   input  logic              i_advance_out,
   output logic              o_last_tap,
   output logic              o_last_out,
   output logic [IN_AW-1:0]  o_in_addr,
   output logic [W_AW-1:0]   o_w_addr,
   output logic [OUT_AW-1:0] o_out_idx
);

   localparam int KW = addr_w(FILTER_SIZE);
   localparam int CW = addr_w(OUT_SIZE);
   localparam int FW = addr_w(NUM_FILTERS);

   localparam logic [KW-1:0]    K_LAST   = KW'(FILTER_SIZE - 1);
   localparam logic [CW-1:0]    O_LAST   = CW'(OUT_SIZE - 1);
   localparam logic [FW-1:0]    F_LAST   = FW'(NUM_FILTERS - 1);
   localparam logic [IN_AW-1:0] IN_STEP  = IN_AW'(INPUT_SIZE);
   localparam logic [IN_AW-1:0] COL_STEP = IN_AW'(STRIDE);
   localparam logic [IN_AW-1:0] ROW_STEP = IN_AW'(STRIDE * INPUT_SIZE);
   localparam logic [W_AW-1:0]  F_STEP   = W_AW'(K);

   logic [KW-1:0]     r_kr, r_kc;
   logic [CW-1:0]     r_r, r_c;
   logic [FW-1:0]     r_f;
   logic [IN_AW-1:0]  r_row_base, r_pos_base, r_tap_row, r_in_addr;
   logic [W_AW-1:0]   r_f_base, r_w_addr;
   logic [OUT_AW-1:0] r_out_idx;

   logic [CW-1:0]     w_r_nxt, w_c_nxt;
   logic [FW-1:0]     w_f_nxt;
   logic [IN_AW-1:0]  w_row_nxt, w_pos_nxt;
   logic [W_AW-1:0]   w_fb_nxt;

   assign o_last_tap = (r_kr == K_LAST) && (r_kc == K_LAST);
   assign o_last_out = (r_f == F_LAST) && (r_r == O_LAST) && (r_c == O_LAST);
   assign o_in_addr  = r_in_addr;
   assign o_w_addr   = r_w_addr;
   assign o_out_idx  = r_out_idx;

   // Next output position and its base addresses (column, then row, then filter).
   always_comb begin
      w_r_nxt   = r_r;
      w_c_nxt   = r_c;
      w_f_nxt   = r_f;
      w_row_nxt = r_row_base;
      w_pos_nxt = r_pos_base;
      w_fb_nxt  = r_f_base;
      if (r_c == O_LAST) begin
         w_c_nxt = '0;
         if (r_r == O_LAST) begin
            w_r_nxt   = '0;
            w_f_nxt   = r_f + FW'(1);
            w_row_nxt = '0;
            w_pos_nxt = '0;
            w_fb_nxt  = r_f_base + F_STEP;
         end else begin
            w_r_nxt   = r_r + CW'(1);
            w_row_nxt = r_row_base + ROW_STEP;
            w_pos_nxt = r_row_base + ROW_STEP;
         end
      end else begin
         w_c_nxt   = r_c + CW'(1);
         w_pos_nxt = r_pos_base + COL_STEP;
      end
   end

   // Counter and address registers; the tap walk rewinds to the position base on its last tap.
   always_ff @(posedge i_clk) begin
      if (i_rst || i_clear) begin
         r_kr       <= '0;
         r_kc       <= '0;
         r_r        <= '0;
         r_c        <= '0;
         r_f        <= '0;
         r_row_base <= '0;
         r_pos_base <= '0;
         r_tap_row  <= '0;
         r_in_addr  <= '0;
         r_f_base   <= '0;
         r_w_addr   <= '0;
         r_out_idx  <= '0;
      end else if (i_advance_out) begin
         r_r        <= w_r_nxt;
         r_c        <= w_c_nxt;
         r_f        <= w_f_nxt;
         r_row_base <= w_row_nxt;
         r_pos_base <= w_pos_nxt;
         r_tap_row  <= w_pos_nxt;
         r_in_addr  <= w_pos_nxt;
         r_f_base   <= w_fb_nxt;
         r_w_addr   <= w_fb_nxt;
         r_out_idx  <= r_out_idx + OUT_AW'(1);
      end else if (i_advance_tap) begin
         if (o_last_tap) begin
            r_kr      <= '0;
            r_kc      <= '0;
            r_tap_row <= r_pos_base;
            r_in_addr <= r_pos_base;
            r_w_addr  <= r_f_base;
         end else if (r_kc == K_LAST) begin
            r_kc      <= '0;
            r_kr      <= r_kr + KW'(1);
            r_tap_row <= r_tap_row + IN_STEP;
            r_in_addr <= r_tap_row + IN_STEP;
            r_w_addr  <= r_w_addr + W_AW'(1);
         end else begin
            r_kc      <= r_kc + KW'(1);
            r_in_addr <= r_in_addr + IN_AW'(1);
            r_w_addr  <= r_w_addr + W_AW'(1);
         end
      end
   end

endmodule

// File: rtl/conv_layer_sequencer.sv
// Time-multiplexed convolution layer: one MAC walks filters, positions and taps.
// Define CONV_SEQ_RELU_EN to clamp negative results to zero on the write path.
module conv_layer_sequencer
   import conv_pkg::*;
#(
   parameter int NUM_FILTERS = 16,
   parameter int INPUT_SIZE  = 28,
   parameter int FILTER_SIZE = 7,
   parameter int STRIDE      = 2,
   localparam int K        = FILTER_SIZE * FILTER_SIZE,
   localparam int OUT_SIZE = out_size(INPUT_SIZE, FILTER_SIZE, STRIDE),
   localparam int IN_AW    = addr_w(INPUT_SIZE * INPUT_SIZE),
   localparam int W_AW     = addr_w(NUM_FILTERS * K),
   localparam int OUT_AW   = addr_w(NUM_FILTERS * OUT_SIZE * OUT_SIZE)
)(
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_start,
   output logic              o_busy,
   output logic              o_done,
   output logic              o_rd_en,
   output logic [IN_AW-1:0]  o_in_addr,
   input  logic [DATA_W-1:0] i_in_data,
   output logic [W_AW-1:0]   o_w_addr,
   input  logic [DATA_W-1:0] i_w_data,
   output logic              o_out_valid,
   input  logic              i_out_ready,
   output logic [OUT_AW-1:0] o_out_addr,
   output logic [DATA_W-1:0] o_out_data
);

   state_t            r_state, w_next;
   logic              r_busy, r_done, r_rd_en, r_acc_en, r_out_valid;
   logic [DATA_W-1:0] r_acc, r_out_data;
   logic [OUT_AW-1:0] r_out_addr;

   logic              w_gen_clear, w_adv_tap, w_adv_out, w_acc_clear;
   logic              w_last_tap, w_last_out;
   logic [OUT_AW-1:0] w_out_idx;
   logic [DATA_W-1:0] w_prod, w_acc_sum, w_out_word;

   conv_seq_addr_gen #(
      .NUM_FILTERS (NUM_FILTERS),
      .INPUT_SIZE  (INPUT_SIZE),
      .FILTER_SIZE (FILTER_SIZE),
      .STRIDE      (STRIDE)
   ) u_addr_gen (
      .i_clk         (i_clk),
      .i_rst         (i_rst),
      .i_clear       (w_gen_clear),
      .i_advance_tap (w_adv_tap),
      .i_advance_out (w_adv_out),
      .o_last_tap    (w_last_tap),
      .o_last_out    (w_last_out),
      .o_in_addr     (o_in_addr),
      .o_w_addr      (o_w_addr),
      .o_out_idx     (w_out_idx)
   );

   // Low 32 bits of the product are identical for signed and unsigned operands.
   assign w_prod    = i_in_data * i_w_data;
   assign w_acc_sum = r_acc + w_prod;

`ifdef CONV_SEQ_RELU_EN
   assign w_out_word = w_acc_sum[DATA_W-1] ? '0 : w_acc_sum;
`else
   assign w_out_word = w_acc_sum;
`endif

   // Next-state and per-cycle control strobes.
   always_comb begin
      w_next      = r_state;
      w_gen_clear = 1'b0;
      w_adv_tap   = 1'b0;
      w_adv_out   = 1'b0;
      w_acc_clear = 1'b0;
      case (r_state)
         IDLE: begin
            if (i_start) begin
               w_next      = MAC;
               w_gen_clear = 1'b1;
               w_acc_clear = 1'b1;
            end else begin
               w_next = IDLE;
            end
         end
         MAC: begin
            w_adv_tap = 1'b1;
            if (w_last_tap) begin
               w_next = DRAIN;
            end else begin
               w_next = MAC;
            end
         end
         DRAIN: w_next = WRITE;
         WRITE: begin
            if (i_out_ready) begin
               if (w_last_out) begin
                  w_next = DONE;
               end else begin
                  w_next      = MAC;
                  w_adv_out   = 1'b1;
                  w_acc_clear = 1'b1;
               end
            end else begin
               w_next = WRITE;
            end
         end
         DONE:    w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   // State, registered status outputs, accumulator and the held output word.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state     <= IDLE;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_rd_en     <= 1'b0;
         r_acc_en    <= 1'b0;
         r_acc       <= '0;
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
         r_out_addr  <= '0;
      end else begin
         r_state  <= w_next;
         r_busy   <= (w_next != IDLE);
         r_done   <= (w_next == DONE);
         r_rd_en  <= (w_next == MAC);
         r_acc_en <= r_rd_en;
         if (w_acc_clear) begin
            r_acc <= '0;
         end else if (r_acc_en) begin
            r_acc <= w_acc_sum;
         end
         if (r_state == DRAIN) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_out_word;
            r_out_addr  <= w_out_idx;
         end else if ((r_state == WRITE) && i_out_ready) begin
            r_out_valid <= 1'b0;
         end
      end
   end

   assign o_busy      = r_busy;
   assign o_done      = r_done;
   assign o_rd_en     = r_rd_en;
   assign o_out_valid = r_out_valid;
   assign o_out_addr  = r_out_addr;
   assign o_out_data  = r_out_data;

endmodule

// File: doc/conv_layer_sequencer.md
# conv_layer_sequencer

Time-multiplexed convolution-layer controller. It computes every output of a multi-filter 2-D convolution with a single 32-bit multiply-accumulate unit. It walks filters, output positions and kernel taps in a fixed order and reads input pixels and filter weights from external synchronous memories. Each finished output is delivered on a valid/ready write port. It replaces a fully unrolled combinational layer wherever area matters more than throughput.

## Interface
- NUM_FILTERS, 16, number of filters
- INPUT_SIZE, 28, input image side (square)
- FILTER_SIZE, 7, kernel side (square); K = FILTER_SIZE²
- STRIDE, 2, kernel step in both axes; OUT_SIZE = (INPUT_SIZE-FILTER_SIZE)/STRIDE+1
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous active-high reset
- start  in  1  one-cycle request to process the layer
- busy  out  1  high while state ≠ IDLE
- done  out  1  one-cycle pulse when the layer is complete
- rd_en  out  1  read strobe for input and weight memories
- in_addr  out  clog2(INPUT_SIZE²)  pixel address, row-major
- in_data  in  32  pixel, valid one cycle after rd_en
- w_addr  out  clog2(NUM_FILTERS·K)  weight address, filter-major then row-major
- w_data  in  32  weight, valid one cycle after rd_en
- out_valid  out  1  output word valid
- out_ready  in  1  sink accepts the word
- out_addr  out  clog2(NUM_FILTERS·OUT_SIZE²)  f·OUT_SIZE² + r·OUT_SIZE + c
- out_data  out  32  signed output

## Operation
- Loop order, outermost first: filter f, output row r, output column c, kernel row kr, kernel column kc.
- Addresses per tap: in_addr = (r·STRIDE+kr)·INPUT_SIZE + c·STRIDE + kc; w_addr = f·K + kr·FILTER_SIZE + kc.
- Generate addresses from incrementing counters and base registers. No runtime multipliers on address paths.
- Arithmetic is two's-complement signed 32-bit. The product is the low 32 bits of in_data·w_data. The accumulator is 32 bits and wraps with no saturation.
- FSM states:
  - IDLE: start=1 → MAC.
  - MAC: accumulator cleared on entry. rd_en=1 and one tap address issued per cycle for K cycles. The tap issued in cycle t is accumulated in cycle t+1. After the K-th issue → DRAIN.
  - DRAIN: rd_en=0; the last tap is accumulated → WRITE.
  - WRITE: out_valid=1 and out_data/out_addr are held stable until out_ready. On the handshake: if this was the last output → DONE, else advance counters → MAC.
  - DONE: done=1 for one cycle → IDLE.
- start is ignored in every state except IDLE.
- rst in any state returns to IDLE, clears counters and the accumulator, and drops out_valid the same edge. A partial layer is abandoned, not resumed.
- Reset values: busy=0, done=0, rd_en=0, out_valid=0, in_addr=0, w_addr=0, out_addr=0, out_data=0.
- out_data and out_addr hold their last written value while outside WRITE.

## Timing
- The cycle in which start is sampled in IDLE is cycle 0. MAC occupies cycles 1..K, DRAIN is cycle K+1, WRITE is cycle K+2 at the earliest.
- Per output: K+2 cycles with out_ready held high. Each cycle of backpressure adds one cycle.
- Whole layer with out_ready constant high: T = NUM_FILTERS·OUT_SIZE²·(K+2). The last handshake occurs in cycle T and done is high in cycle T+1.
- Memory read latency is exactly one cycle, fixed. There is no stall input on the read side.
- busy rises in cycle 1 and falls in the cycle after done.

## Configuration
- CONV_SEQ_RELU_EN defined: out_data = (acc < 0) ? 0 : acc, i.e. ReLU applied on the WRITE path only; the accumulator itself is unaffected.
- CONV_SEQ_RELU_EN undefined: out_data = acc unchanged.
- Timing is identical in both builds.

## Structure
- Shared package conv_pkg holds:
  - the data width constant (32)
  - an out_size(input_size, filter_size, stride) function
  - the FSM state enum (IDLE, MAC, DRAIN, WRITE, DONE)
- One sub-module, conv_seq_addr_gen. It owns the f/r/c/kr/kc counters and the incremental address registers. It exposes advance_tap, advance_out, last_tap and last_out to the FSM.
- The MAC, accumulator and FSM live in the top.

## Test plan
- NF=2, IN=5, FS=3, STRIDE=1 (OUT=3), all pixels 1, all weights 1, out_ready high → 18 writes with out_data=9, out_addr 0..17 in order, done in cycle 199.
- NF=1, IN=5, FS=3, STRIDE=2 (OUT=2), pixel[i]=i, weights 1 → out_data 54, 72, 144, 162; observed in_addr sequence for output 1 starts 2,3,4,7.
- pixel 0x7FFFFFFF at tap 0, weight 2, all else 0 → out_data 0xFFFFFFFE (wrap); weights -1 with pixels 1 → -9 without CONV_SEQ_RELU_EN, 0 with it.
- Random out_ready (50%) → out_data/out_addr stable while out_valid && !out_ready; every word delivered exactly once; done count unchanged.
- rst asserted in cycle 40 mid-MAC, start again two cycles later → all outputs at reset values after the rst edge, and a full correct layer completes from scratch.
- start pulsed while busy → no effect; exactly one done per accepted start.
